// File: rtl/grs_align.sv
// Multi-cycle right-shift aligner producing {significand>>shamt, G, R, S} for the FP MAC rounding stage.
// At most STEP bits are shifted per cycle; the result is held until the downstream handshake.
module grs_align #(
  parameter int WIDTH = 26,
  parameter int STEP  = 4,
  parameter int SHW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-4:0] in_mant,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [SHW:0]   LP_WIDTH = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] LP_STEP  = SHW'(STEP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_rem;

  logic             w_zero;
  logic             w_big;
  logic [SHW-1:0]   w_k;
  logic [SHW-1:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_acc_shift;

  assign w_zero    = (in_shamt == '0);
  assign w_big     = ({1'b0, in_shamt} >= LP_WIDTH);
  assign w_k       = (r_rem < LP_STEP) ? r_rem : LP_STEP;
  assign w_rem_nxt = r_rem - w_k;

  // The mask covers the k bits leaving the word; old bit0 is among them, so sticky is preserved.
  assign w_mask      = (WIDTH'(1) << w_k) - WIDTH'(1);
  assign w_acc_shift = (r_acc >> w_k) | {{(WIDTH-1){1'b0}}, |(r_acc & w_mask)};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves the output unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = (w_zero || w_big) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_rem_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  // out_data is the working register itself: it only changes on a load or while shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_rem <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem <= in_shamt;
            r_acc <= w_big ? {{(WIDTH-1){1'b0}}, |in_mant} : {in_mant, 3'b000};
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_shift;
          r_rem <= w_rem_nxt;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_acc;

endmodule

// File: tb/tb_grs_align.sv
// Directed and randomised checks of grs_align (WIDTH=26, STEP=4) against hand values and a one-shot shift model.
module tb_grs_align;

  localparam int WIDTH = 26;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-4:0]  in_mant = '0;
  logic [7:0]        in_shamt = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_data;
  logic              busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  grs_align #(.WIDTH(WIDTH), .STEP(4), .SHW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Whole shift in one step, sticky = OR of every bit that falls off the bottom.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-4:0] m, input int s);
    logic [WIDTH-1:0] full;
    logic [WIDTH-1:0] lost_mask;
    full = {m, 3'b000};
    if (s == 0) return full;
    if (s >= WIDTH) return {{(WIDTH-1){1'b0}}, |m};
    lost_mask = (WIDTH'(1) << s) - WIDTH'(1);
    return (full >> s) | {{(WIDTH-1){1'b0}}, |(full & lost_mask)};
  endfunction

  // Called just after a posedge with the DUT idle; returns with out_valid seen (or the bound hit).
  task automatic launch(input logic [WIDTH-4:0] m, input logic [7:0] s, output int lat);
    in_mant  = m;
    in_shamt = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-4:0] m, input logic [7:0] s,
                        input logic [WIDTH-1:0] exp_data, input int exp_lat);
    int lat;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    launch(m, s, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  typedef struct {
    string            tag;
    logic [WIDTH-4:0] mant;
    logic [7:0]       shamt;
    logic [WIDTH-1:0] data;
    int               lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [WIDTH-1:0] held;
    logic saw_valid;
    logic [WIDTH-1:0] exp_q[$];
    int sent, rcvd;

    vecs.push_back('{"zero_shift",  23'h400000,  8'd0, 26'h2000000, 1});
    vecs.push_back('{"shift5",      23'h7FFFFF,  8'd5, 26'h01FFFFF, 3});
    vecs.push_back('{"round_bit",   23'h000001,  8'd2, 26'h0000002, 2});
    vecs.push_back('{"sticky_only", 23'h000001, 8'd30, 26'h0000001, 1});
    vecs.push_back('{"all_zero",    23'h000000, 8'd30, 26'h0000000, 1});
    vecs.push_back('{"shamt_width", 23'h7FFFFF, 8'd26, 26'h0000001, 1});
    vecs.push_back('{"shamt_w_m1",  23'h400000, 8'd25, 26'h0000001, 8});
    vecs.push_back('{"step_exact",  23'h000001,  8'd4, 26'h0000001, 2});
    vecs.push_back('{"shift8",      23'h7FFFFF,  8'd8, 26'h003FFFF, 3});

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].mant, vecs[i].shamt, vecs[i].data, vecs[i].lat);

    // Backpressure: result must hold and a request during DONE must be dropped.
    out_ready = 1'b0;
    launch(23'h5A5A5A, 8'd9, lat);
    check("bp_lat", 32'(lat), 32'd4);
    check("bp_data", 32'(out_data), 32'h0016969);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(held));
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 1);
      in_mant  = 23'h7FFFFF;
      in_shamt = 8'd0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_data", 32'(out_data), 32'(held));
    saw_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw_valid |= out_valid | busy;
    end
    check("bp_dropped", 32'(saw_valid), 32'd0);

    // Reset in the second SHIFT cycle.
    in_mant  = 23'h7FFFFF;
    in_shamt = 8'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rm_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("rm_busy2", {30'd0, busy, out_valid}, 32'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(in_ready), 32'd1);
    check("rm_data", 32'(out_data), 32'd0);
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    check("rm_no_result", 32'(saw_valid), 32'd0);

    // Random traffic with random downstream stalls.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 5000 && rcvd < 50; cyc++) begin
      in_valid = 1'b0;
      if (in_ready && sent < 50 && $urandom_range(0, 3) != 0) begin
        in_mant  = 23'($urandom);
        in_shamt = 8'($urandom_range(0, 40));
        in_valid = 1'b1;
        exp_q.push_back(model(in_mant, int'(in_shamt)));
        sent++;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_extra", 32'd1, 32'd0);
        else check("rand_data", 32'(out_data), 32'(exp_q.pop_front()));
        rcvd++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rand_count", 32'(rcvd), 32'd50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
